mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (loads/stores).
- Sequences each access over a fixed memory latency and returns the fetched instruction or load data.
- Generates `pc_enable` and a MEM stall so the PC advances exactly once per completed fetch.
- Honours the halt detected in IF: halt stops further fetching but still serves data accesses.

Parameters:
- MEM_LATENCY, 2, cycles from address presentation to valid `mem_rdata`. Legal values are 1 to 15.
- ADDR_W, 32, width of the address buses.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  IF requests an instruction; held until `if_valid`
- if_addr  in  ADDR_W  fetch address (the PC)
- if_inst  out  32  fetched instruction; registered, holds its last value
- if_valid  out  1  one-cycle pulse when `if_inst` is updated
- pc_enable  out  1  PC advance strobe to the PC controller
- halt  in  1  halt instruction detected in IF
- halted  out  1  sticky halted status
- d_req  in  1  MEM requests a data access; held until `d_done`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data; registered, holds its last value
- d_done  out  1  one-cycle pulse on completion of a load or store
- mem_stall  out  1  stalls the pipeline while a data access is outstanding
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Reset (asynchronous, `rst_n` = 0): all outputs are 0 and the FSM is in IDLE.
  - Latency counter = 0, `halted` = 0, `last_grant` = DATA, so fetch wins the first tie.
  - Reset during an access abandons it; no done/valid pulse is produced.
- FSM states: IDLE, FETCH, DATA.
- IDLE, arbitration each cycle:
  - Only `d_req`: go to DATA.
  - Only `if_req` and `halted` = 0: go to FETCH.
  - Both pending: grant the requester other than `last_grant` (alternating priority, so neither side starves).
  - Neither pending: stay in IDLE.
- On grant:
  - Latch the address, plus `d_we` and `d_wdata` for DATA.
  - Counter = 0.
  - Set `last_grant` to the granted side.
- FETCH and DATA:
  - `mem_en` = 1. `mem_addr`, `mem_we` and `mem_wdata` come from the latched values and are stable for the whole access.
  - `mem_we` = 1 only in DATA with a store.
  - The counter increments each cycle.
  - When counter = MEM_LATENCY-1, on that edge:
    - Capture `mem_rdata` into `if_inst` (FETCH) or into `d_rdata` (DATA load only; stores leave `d_rdata` unchanged).
    - Pulse `if_valid` or `d_done` for the next cycle.
    - Return to IDLE.
- Latency and throughput:
  - The response pulse is high exactly MEM_LATENCY cycles after the grant edge.
  - Throughput is one access per MEM_LATENCY+1 cycles, because IDLE takes one arbitration cycle.
- Strobe outputs:
  - `pc_enable` = `if_valid`: a registered one-cycle pulse, one per fetch.
  - `mem_stall` = `d_req` AND NOT `d_done`, combinational.
- Request drops mid-access:
  - This is a protocol violation.
  - The access still completes and still pulses.
  - The next arbitration uses the live request levels.
- Halt:
  - `halt` = 1 in any cycle sets `halted`; only reset clears it.
  - A fetch already in progress completes normally, including its `pc_enable` pulse.
  - No new FETCH is granted while `halted` = 1.
  - DATA accesses continue to be served.
- Simultaneous `halt` and grant: a fetch granted on the same edge that `halted` sets is suppressed, because halt is checked before granting FETCH.
- Address width: addresses are passed through unmodified; no alignment check or translation.

Test Plan:
- Basic fetch: MEM_LATENCY = 2; reset then release; `if_req` = 1, `if_addr` = 0x0, memory returns 0x20080005 -> `mem_en` high for 2 cycles with `mem_addr` = 0x0; `if_valid` and `pc_enable` pulse once; `if_inst` = 0x20080005.
- Load vs fetch tie: both requests rise together after reset -> FETCH granted first (`last_grant` = DATA). Then DATA is granted with `d_addr` = 0x100; `d_rdata` = `mem_rdata` = 0xDEADBEEF; `mem_stall` is high until the `d_done` cycle.
- Store: `d_we` = 1, `d_addr` = 0x40, `d_wdata` = 0x12345678 -> `mem_we` = 1 for exactly MEM_LATENCY cycles with stable address and data; `d_done` pulses once; `d_rdata` is unchanged.
- Fairness: hold `if_req` and `d_req` high continuously for 12 accesses -> grants alternate F, D, F, D, …; 6 `if_valid` and 6 `d_done` pulses; each pulse spaced MEM_LATENCY+1 cycles apart.
- Halt: pulse `halt` during a fetch (fetch instruction 0x0000000C) -> the fetch completes with one `pc_enable` pulse; `halted` = 1; `if_req` is then ignored for 20 cycles while a subsequent `d_req` load still completes.
- Reset mid-access: assert `rst_n` = 0 during the second cycle of a DATA access -> all outputs are 0 immediately and no `d_done` pulse occurs. After release, a pending `if_req` is granted first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch
// and data access, sequencing each access over a fixed latency.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_inst,
    output logic              if_valid,
    output logic              pc_enable,
    input  logic              halt,
    output logic              halted,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              mem_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_last_data;
    logic              r_halted;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [31:0]       r_if_inst;
    logic [31:0]       r_d_rdata;
    logic              r_if_valid;
    logic              r_d_done;

    logic              w_halt_eff;
    logic              w_can_fetch;
    logic              w_grant_f;
    logic              w_grant_d;
    logic              w_last;

    // A halt seen on this edge already blocks a fetch grant on the same edge.
    assign w_halt_eff  = r_halted | halt;
    assign w_can_fetch = if_req & ~w_halt_eff;
    assign w_last      = (r_cnt == LAST_CNT);

    always_comb begin
        w_grant_f   = 1'b0;
        w_grant_d   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_can_fetch && d_req) begin
                    w_grant_f = r_last_data;
                    w_grant_d = ~r_last_data;
                end else begin
                    w_grant_f = w_can_fetch;
                    w_grant_d = d_req;
                end
                if (w_grant_f) begin
                    w_state_nxt = S_FETCH;
                end else if (w_grant_d) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_FETCH, S_DATA: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_last_data <= 1'b1;
            r_halted    <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= 32'd0;
            r_if_inst   <= 32'd0;
            r_d_rdata   <= 32'd0;
            r_if_valid  <= 1'b0;
            r_d_done    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_halted   <= w_halt_eff;
            r_if_valid <= 1'b0;
            r_d_done   <= 1'b0;
            if (w_grant_f || w_grant_d) begin
                r_cnt       <= 4'd0;
                r_last_data <= w_grant_d;
                r_addr      <= w_grant_d ? d_addr : if_addr;
                r_we        <= w_grant_d & d_we;
                if (w_grant_d) begin
                    r_wdata <= d_wdata;
                end
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 4'd1;
                if (w_last) begin
                    if (r_state == S_FETCH) begin
                        r_if_inst  <= mem_rdata;
                        r_if_valid <= 1'b1;
                    end else begin
                        // Stores complete without disturbing the last load data.
                        if (!r_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                        r_d_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign if_inst   = r_if_inst;
    assign if_valid  = r_if_valid;
    assign pc_enable = r_if_valid;
    assign halted    = r_halted;
    assign d_rdata   = r_d_rdata;
    assign d_done    = r_d_done;
    assign mem_stall = d_req & ~r_d_done;
    assign mem_en    = (r_state != S_IDLE);
    assign mem_we    = (r_state == S_DATA) & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a timestamp-based access model.
module tb_mem_port_arbiter;

    localparam int L  = 2;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, halt, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [31:0]   d_wdata, mem_rdata;
    logic [31:0]   if_inst, d_rdata, mem_wdata;
    logic          if_valid, pc_enable, halted, d_done, mem_stall, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [1:0]    dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    bit rand_mem = 1'b0;

    mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst),
        .if_valid(if_valid), .pc_enable(pc_enable),
        .halt(halt), .halted(halted),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .mem_stall(mem_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock / memory responder ----------------
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   rom = 32'h20080005;
            32'h4:   rom = 32'h0000000C;
            32'h100: rom = 32'hDEADBEEF;
            default: rom = a ^ 32'hA5A5A5A5;
        endcase
    endfunction

    always @(negedge clk) mem_rdata = rand_mem ? $urandom : rom(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each access is described by its grant edge and completion edge.
    int          edge_n = 0;
    int          busy_until = -1;
    int          g_edge = -1;
    bit          m_data, m_we, m_last_data, m_halted, e_if_valid, e_d_done, e_en;
    bit          can_f, take_d;
    logic [31:0] m_addr, m_wdata, e_if_inst, e_d_rdata;
    bit          s_rst, s_if_req, s_d_req, s_d_we, s_halt;
    logic [31:0] s_if_addr, s_d_addr, s_d_wdata, s_rdata;

    always @(posedge clk) begin
        s_rst = rst_n; s_if_req = if_req; s_d_req = d_req; s_d_we = d_we;
        s_halt = halt; s_if_addr = if_addr; s_d_addr = d_addr;
        s_d_wdata = d_wdata; s_rdata = mem_rdata;
        edge_n++;
        e_if_valid = 1'b0;
        e_d_done   = 1'b0;
        if (!s_rst) begin
            busy_until = -1; g_edge = -1; m_last_data = 1'b1; m_halted = 1'b0;
            e_if_inst = 32'd0; e_d_rdata = 32'd0; m_addr = 32'd0; m_wdata = 32'd0;
            m_we = 1'b0; m_data = 1'b0;
        end else begin
            if (edge_n == busy_until) begin
                if (!m_data) begin
                    e_if_inst  = s_rdata;
                    e_if_valid = 1'b1;
                end else begin
                    if (!m_we) e_d_rdata = s_rdata;
                    e_d_done = 1'b1;
                end
            end else if (edge_n > busy_until) begin
                can_f = s_if_req && !(m_halted || s_halt);
                if (can_f || s_d_req) begin
                    take_d      = (can_f && s_d_req) ? !m_last_data : s_d_req;
                    g_edge      = edge_n;
                    busy_until  = edge_n + L;
                    m_data      = take_d;
                    m_last_data = take_d;
                    m_addr      = take_d ? s_d_addr : s_if_addr;
                    m_we        = take_d && s_d_we;
                    if (take_d) m_wdata = s_d_wdata;
                end
            end
            m_halted = m_halted || s_halt;
        end
        #1;
        e_en = (g_edge <= edge_n) && (edge_n < busy_until);
        check("m_if_inst", if_inst, e_if_inst);
        check("m_if_valid", 32'(if_valid), 32'(e_if_valid));
        check("m_pc_enable", 32'(pc_enable), 32'(e_if_valid));
        check("m_halted", 32'(halted), 32'(m_halted));
        check("m_d_rdata", d_rdata, e_d_rdata);
        check("m_d_done", 32'(d_done), 32'(e_d_done));
        check("m_mem_en", 32'(mem_en), 32'(e_en));
        check("m_mem_we", 32'(mem_we), 32'(e_en && m_data && m_we));
        check("m_mem_stall", 32'(mem_stall), 32'(d_req && !e_d_done));
        if (e_en) check("m_mem_addr", mem_addr, m_addr);
        if (e_en && m_data && m_we) check("m_mem_wdata", mem_wdata, m_wdata);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pulse(input bit want_data, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (want_data ? d_done : if_valid) ok = 1'b1;
        end
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, "_if_inst"}, if_inst, 32'd0);
        check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        check({tag, "_pc_enable"}, 32'(pc_enable), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
        check({tag, "_d_done"}, 32'(d_done), 32'd0);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    int n_en, n_pc, n_d, n_f, pulses, cyc, last_cyc;
    bit ok;
    logic [31:0] seen;

    initial begin
        rst_n = 1'b0; if_req = 1'b0; halt = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_zero("rst");
        @(negedge clk) rst_n = 1'b1;

        // basic fetch
        @(negedge clk); if_req = 1'b1; if_addr = 32'h0;
        n_en = 0; ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (mem_en) begin
                n_en++;
                check("fetch_addr", mem_addr, 32'h0);
            end
            if (if_valid) ok = 1'b1;
        end
        check("fetch_done", 32'(ok), 32'd1);
        check("fetch_en_cycles", n_en, L);
        check("fetch_inst", if_inst, 32'h20080005);
        check("fetch_pc_enable", 32'(pc_enable), 32'd1);
        @(negedge clk) if_req = 1'b0;
        n_pc = 0;
        for (int i = 0; i < 6; i++) begin tick(); n_pc += int'(pc_enable); end
        check("fetch_single_pulse", n_pc, 0);

        // tie after reset: fetch first, then load
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (if_valid || d_done) ok = 1'b1;
        end
        check("tie_first_is_fetch", 32'({if_valid, d_done}), 32'h2);
        @(negedge clk) if_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (d_done) ok = 1'b1;
            else check("tie_stall_pending", 32'(mem_stall), 32'd1);
        end
        check("tie_load_done", 32'(ok), 32'd1);
        check("tie_stall_at_done", 32'(mem_stall), 32'd0);
        check("tie_load_data", d_rdata, 32'hDEADBEEF);
        @(negedge clk) d_req = 1'b0;

        // store
        @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
        n_en = 0; ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (mem_we) begin
                n_en++;
                check("store_addr", mem_addr, 32'h40);
                check("store_wdata", mem_wdata, 32'h12345678);
            end
            if (d_done) ok = 1'b1;
        end
        check("store_done", 32'(ok), 32'd1);
        check("store_we_cycles", n_en, L);
        check("store_rdata_kept", d_rdata, 32'hDEADBEEF);
        @(negedge clk); d_req = 1'b0; d_we = 1'b0;
        n_d = 0;
        for (int i = 0; i < 5; i++) begin tick(); n_d += int'(d_done); end
        check("store_single_done", n_d, 0);

        // fairness with both requests held
        for (int j = 0; j < 12; j++) exp_q.push_back(32'(j % 2));
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        pulses = 0; cyc = 0; last_cyc = 0; n_f = 0; n_d = 0;
        for (int i = 0; i < 100 && pulses < 12; i++) begin
            tick();
            cyc++;
            if (if_valid || d_done) begin
                check("fair_order", 32'(d_done), exp_q.pop_front());
                if (pulses > 0) check("fair_spacing", cyc - last_cyc, L + 1);
                last_cyc = cyc;
                pulses++;
                n_f += int'(if_valid);
                n_d += int'(d_done);
            end
        end
        @(negedge clk); if_req = 1'b0; d_req = 1'b0;
        check("fair_pulses", pulses, 12);
        check("fair_fetches", n_f, 6);
        check("fair_datas", n_d, 6);
        repeat (6) tick();

        // random traffic
        rand_mem = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (if_req) begin
                if (if_valid || $urandom_range(0, 40) == 0) if_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (d_req) begin
                if (d_done || $urandom_range(0, 40) == 0) d_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
        end
        @(negedge clk); if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        repeat (8) tick();
        rand_mem = 1'b0;
        repeat (2) tick();

        // halt during a fetch
        @(negedge clk); if_req = 1'b1; if_addr = 32'h4;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin tick(); if (mem_en) ok = 1'b1; end
        check("halt_fetch_granted", 32'(ok), 32'd1);
        @(negedge clk) halt = 1'b1;
        @(negedge clk) halt = 1'b0;
        wait_pulse(1'b0, 10, ok);
        check("halt_fetch_done", 32'(ok), 32'd1);
        check("halt_fetch_inst", if_inst, 32'h0000000C);
        n_pc = int'(pc_enable);
        @(negedge clk) if_req = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); n_pc += int'(pc_enable); end
        check("halt_fetch_pc_pulses", n_pc, 1);
        check("halted_set", 32'(halted), 32'd1);
        @(negedge clk); if_req = 1'b1; if_addr = 32'h8;
        n_pc = 0; n_d = 0; seen = 32'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_pc += int'(pc_enable);
            n_d  += int'(d_done);
            if (d_done) begin seen = d_rdata; d_req = 1'b0; end
            if (i == 3) begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; end
        end
        check("halt_no_fetch", n_pc, 0);
        check("halt_load_done", n_d, 1);
        check("halt_load_data", seen, 32'hDEADBEEF);
        check("halted_sticky", 32'(halted), 32'd1);

        // reset during the second cycle of a data access
        @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; if_addr = 32'h0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin tick(); if (mem_en) ok = 1'b1; end
        check("rmid_data_granted", 32'({ok, mem_we, mem_addr == 32'h100}), 32'h5);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_zero("rmid");
        n_d = 0;
        for (int i = 0; i < 2; i++) begin tick(); n_d += int'(d_done); end
        check("rmid_no_done", n_d, 0);
        @(negedge clk) rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            n_d += int'(d_done);
            if (if_valid || d_done) ok = 1'b1;
        end
        check("rmid_fetch_first", 32'({if_valid, d_done}), 32'h2);
        check("rmid_fetch_inst", if_inst, 32'h20080005);
        @(negedge clk) if_req = 1'b0;
        wait_pulse(1'b1, 10, ok);
        check("rmid_load_after", 32'(ok), 32'd1);
        @(negedge clk) d_req = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
